// File: rtl/scoreboard_if.sv
// Scoreboard types plus the issue/writeback/commit/forwarding bundle.
// Optional operand forwarding in the scoreboard is enabled with SB_FORWARD_EN.
package scoreboard_pkg;
  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception                 ex;
  } scoreboard_entry;
endpackage

interface scoreboard_if #(
  parameter int unsigned NR_WB_PORTS = 4
);
  import scoreboard_pkg::*;

  logic                                       flush_i;
  logic                                       full_o;
  scoreboard_entry                            decoded_instr_i;
  logic                                       decoded_instr_valid_i;
  logic                                       decoded_instr_ack_o;
  logic [TRANS_ID_BITS-1:0]                   issue_trans_id_o;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  trans_id_i;
  logic [NR_WB_PORTS-1:0][63:0]               wdata_i;
  logic [NR_WB_PORTS-1:0]                     wb_valid_i;
  exception [NR_WB_PORTS-1:0]                 ex_i;
  scoreboard_entry                            commit_instr_o;
  logic                                       commit_valid_o;
  logic                                       commit_ack_i;
  logic [4:0]                                 rs1_i;
  logic [4:0]                                 rs2_i;
  logic [63:0]                                rs1_o;
  logic [63:0]                                rs2_o;
  logic                                       rs1_valid_o;
  logic                                       rs2_valid_o;
  logic                                       rs1_busy_o;
  logic                                       rs2_busy_o;

  modport master (
    output flush_i, decoded_instr_i, decoded_instr_valid_i, trans_id_i, wdata_i,
           wb_valid_i, ex_i, commit_ack_i, rs1_i, rs2_i,
    input  full_o, decoded_instr_ack_o, issue_trans_id_o, commit_instr_o, commit_valid_o,
           rs1_o, rs2_o, rs1_valid_o, rs2_valid_o, rs1_busy_o, rs2_busy_o
  );

  modport slave (
    input  flush_i, decoded_instr_i, decoded_instr_valid_i, trans_id_i, wdata_i,
           wb_valid_i, ex_i, commit_ack_i, rs1_i, rs2_i,
    output full_o, decoded_instr_ack_o, issue_trans_id_o, commit_instr_o, commit_valid_o,
           rs1_o, rs2_o, rs1_valid_o, rs2_valid_o, rs1_busy_o, rs2_busy_o
  );
endinterface

// File: rtl/scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard.
// Define SB_FORWARD_EN to forward finished results on rs*_o / rs*_valid_o.
module scoreboard import scoreboard_pkg::*; #(
  parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  scoreboard_if.slave  sb
);

  localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic [63:0] data;
  } lookup_t;

  scoreboard_entry          mem_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]    occ_q;
  logic [TRANS_ID_BITS-1:0] head_q, tail_q;
  logic [CNT_W-1:0]         count_q;

  logic            full, alloc, commit;
  scoreboard_entry alloc_entry;
  lookup_t         rs1_res, rs2_res;

  function automatic logic [TRANS_ID_BITS-1:0] next_ptr(input logic [TRANS_ID_BITS-1:0] p);
    return (p == TRANS_ID_BITS'(NR_ENTRIES - 1)) ? '0 : p + TRANS_ID_BITS'(1);
  endfunction

  // Walk from head towards tail so the last hit is the youngest producer.
  function automatic lookup_t lookup(input logic [4:0] rs);
    lookup_t                  res;
    logic [TRANS_ID_BITS-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      idx = TRANS_ID_BITS'((32'(head_q) + i) % NR_ENTRIES);
      if (i < 32'(count_q) && rs != '0 && mem_q[idx].rd == rs) begin
        res.busy = 1'b1;
`ifdef SB_FORWARD_EN
        res.valid = mem_q[idx].valid;
        res.data  = mem_q[idx].valid ? mem_q[idx].result : '0;
`else
        res.valid = 1'b0;
        res.data  = '0;
`endif
      end
    end
    return res;
  endfunction

  assign full                   = (count_q == CNT_W'(NR_ENTRIES));
  assign alloc                  = sb.decoded_instr_valid_i & ~full & ~sb.flush_i;
  assign sb.full_o              = full;
  assign sb.decoded_instr_ack_o = alloc;
  assign sb.issue_trans_id_o    = tail_q;
  assign sb.commit_instr_o      = mem_q[head_q];
  assign sb.commit_valid_o      = (count_q != '0) & mem_q[head_q].valid & ~sb.flush_i;
  assign commit                 = sb.commit_ack_i & sb.commit_valid_o;

  always_comb begin
    alloc_entry          = sb.decoded_instr_i;
    alloc_entry.trans_id = tail_q;
    alloc_entry.valid    = 1'b0;
  end

  always_comb begin
    rs1_res = lookup(sb.rs1_i);
    rs2_res = lookup(sb.rs2_i);
  end

  assign sb.rs1_busy_o  = rs1_res.busy;
  assign sb.rs1_valid_o = rs1_res.valid;
  assign sb.rs1_o       = rs1_res.data;
  assign sb.rs2_busy_o  = rs2_res.busy;
  assign sb.rs2_valid_o = rs2_res.valid;
  assign sb.rs2_o       = rs2_res.data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (sb.flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Later ports override earlier ones; commit/alloc below override writebacks.
      for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
        if (sb.wb_valid_i[k] && occ_q[sb.trans_id_i[k]]) begin
          mem_q[sb.trans_id_i[k]].result <= sb.wdata_i[k];
          mem_q[sb.trans_id_i[k]].valid  <= 1'b1;
          if (sb.ex_i[k].valid) mem_q[sb.trans_id_i[k]].ex <= sb.ex_i[k];
        end
      end
      if (commit) begin
        mem_q[head_q] <= '0;
        occ_q[head_q] <= 1'b0;
        head_q        <= next_ptr(head_q);
      end
      if (alloc) begin
        mem_q[tail_q] <= alloc_entry;
        occ_q[tail_q] <= 1'b1;
        tail_q        <= next_ptr(tail_q);
      end
      case ({alloc, commit})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench: allocations push expected commits into a queue, a
// separate monitor pops and compares on every retired entry.
module tb_scoreboard;
  import scoreboard_pkg::*;

`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [1:0]  id;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        exv;
    logic [63:0] cause;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  scoreboard_if #(.NR_WB_PORTS(4)) sb_if ();

  scoreboard #(.NR_ENTRIES(4), .NR_WB_PORTS(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every retired entry must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && sb_if.commit_valid_o && sb_if.commit_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL commit_unexpected: got id %0d, expected no commit",
                 sb_if.commit_instr_o.trans_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_id",     64'(sb_if.commit_instr_o.trans_id), 64'(e.id));
        chk("commit_rd",     64'(sb_if.commit_instr_o.rd),       64'(e.rd));
        chk("commit_result", sb_if.commit_instr_o.result,        e.result);
        chk("commit_exv",    64'(sb_if.commit_instr_o.ex.valid), 64'(e.exv));
        chk("commit_cause",  sb_if.commit_instr_o.ex.cause,      e.cause);
      end
    end
  end

  task automatic idle();
    sb_if.flush_i               = 1'b0;
    sb_if.decoded_instr_i       = '0;
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.trans_id_i            = '0;
    sb_if.wdata_i               = '0;
    sb_if.wb_valid_i            = '0;
    sb_if.ex_i                  = '0;
    sb_if.commit_ack_i          = 1'b0;
  endtask

  // Garbage trans_id / valid in the request must be overwritten on allocation.
  task automatic alloc_set(input logic [4:0] rd);
    sb_if.decoded_instr_i          = '0;
    sb_if.decoded_instr_i.pc       = 64'h8000_0000;
    sb_if.decoded_instr_i.rd       = rd;
    sb_if.decoded_instr_i.trans_id = 2'b11;
    sb_if.decoded_instr_i.valid    = 1'b1;
    sb_if.decoded_instr_valid_i    = 1'b1;
  endtask

  task automatic wb(input int port, input logic [1:0] id, input logic [63:0] data,
                    input logic exv, input logic [63:0] cause);
    sb_if.wb_valid_i[port]     = 1'b1;
    sb_if.trans_id_i[port]     = id;
    sb_if.wdata_i[port]        = data;
    sb_if.ex_i[port].valid     = exv;
    sb_if.ex_i[port].cause     = cause;
    sb_if.ex_i[port].tval      = 64'h0;
  endtask

  task automatic push(input logic [1:0] id, input logic [4:0] rd, input logic [63:0] res,
                      input logic exv, input logic [63:0] cause);
    exp_t e;
    e.id = id; e.rd = rd; e.result = res; e.exv = exv; e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    logic [63:0] fill_res [4];
    fill_res[0] = 64'h100; fill_res[1] = 64'h111; fill_res[2] = 64'h222; fill_res[3] = 64'h333;
    clk = 1'b0; rst_n = 1'b0; checks = 0; failures = 0;
    idle();
    sb_if.rs1_i = 5'd5; sb_if.rs2_i = 5'd0;

    // Reset values
    @(negedge clk);
    chk("rst_full", 64'(sb_if.full_o), 64'd0);
    chk("rst_commit_valid", 64'(sb_if.commit_valid_o), 64'd0);
    chk("rst_issue_id", 64'(sb_if.issue_trans_id_o), 64'd0);
    chk("rst_rs1_busy", 64'(sb_if.rs1_busy_o), 64'd0);
    chk("rst_rs1_valid", 64'(sb_if.rs1_valid_o), 64'd0);
    chk("rst_rs1_data", sb_if.rs1_o, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Fill: ids 0..3, then refusal
    for (int i = 0; i < 4; i++) begin
      alloc_set(5'(i + 1));
      push(2'(i), 5'(i + 1), fill_res[i], i == 3, (i == 3) ? 64'h5 : 64'h0);
      @(negedge clk);
      chk("fill_ack", 64'(sb_if.decoded_instr_ack_o), 64'd1);
      chk("fill_id", 64'(sb_if.issue_trans_id_o), 64'(i));
      next_cycle();
    end
    sb_if.rs1_i = 5'd3;
    alloc_set(5'd9);
    @(negedge clk);
    chk("fill_full", 64'(sb_if.full_o), 64'd1);
    chk("fill_5th_ack", 64'(sb_if.decoded_instr_ack_o), 64'd0);
    chk("fill_commit_valid", 64'(sb_if.commit_valid_o), 64'd0);
    chk("busy_rd3", 64'(sb_if.rs1_busy_o), 64'd1);
    chk("busy_rd3_valid", 64'(sb_if.rs1_valid_o), 64'd0);
    next_cycle();

    // Out-of-order writeback: id2 first, then id0
    wb(0, 2'd2, 64'h222, 1'b0, 64'h0);
    next_cycle();
    wb(1, 2'd0, 64'h100, 1'b0, 64'h0);
    @(negedge clk);
    chk("ooo_cv_before_id0", 64'(sb_if.commit_valid_o), 64'd0);
    next_cycle();
    // Full with simultaneous commit and allocate
    sb_if.commit_ack_i = 1'b1;
    alloc_set(5'd10);
    @(negedge clk);
    chk("ooo_cv_after_id0", 64'(sb_if.commit_valid_o), 64'd1);
    chk("full_commit_ack", 64'(sb_if.decoded_instr_ack_o), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("full_after_commit", 64'(sb_if.full_o), 64'd0);
    chk("cv_head1_pending", 64'(sb_if.commit_valid_o), 64'd0);
    chk("tail_wrapped", 64'(sb_if.issue_trans_id_o), 64'd0);
    next_cycle();
    wb(2, 2'd1, 64'h111, 1'b0, 64'h0);
    next_cycle();
    sb_if.commit_ack_i = 1'b1;
    @(negedge clk);
    chk("cv_id1", 64'(sb_if.commit_valid_o), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cv_id2", 64'(sb_if.commit_valid_o), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("cv_id3_pending", 64'(sb_if.commit_valid_o), 64'd0);
    next_cycle();

    // Writebacks to a slot being allocated and to a free slot are dropped
    alloc_set(5'd6);
    wb(0, 2'd0, 64'hBAD, 1'b0, 64'h0);
    wb(1, 2'd1, 64'hBAD1, 1'b0, 64'h0);
    push(2'd0, 5'd6, 64'h600, 1'b0, 64'h0);
    @(negedge clk);
    chk("alloc_id0_ack", 64'(sb_if.decoded_instr_ack_o), 64'd1);
    chk("alloc_id0_id", 64'(sb_if.issue_trans_id_o), 64'd0);
    next_cycle();
    // Two ports on id3: port 3 wins and carries an exception
    wb(0, 2'd3, 64'hAAA, 1'b0, 64'h0);
    wb(3, 2'd3, 64'h333, 1'b1, 64'h5);
    next_cycle();
    sb_if.commit_ack_i = 1'b1;
    @(negedge clk);
    chk("cv_id3", 64'(sb_if.commit_valid_o), 64'd1);
    next_cycle();
    sb_if.rs1_i = 5'd6;
    @(negedge clk);
    chk("dropped_wb_cv", 64'(sb_if.commit_valid_o), 64'd0);
    chk("busy_rd6", 64'(sb_if.rs1_busy_o), 64'd1);
    chk("busy_rd6_valid", 64'(sb_if.rs1_valid_o), 64'd0);
    next_cycle();
    wb(2, 2'd0, 64'h600, 1'b0, 64'h0);
    next_cycle();
    sb_if.commit_ack_i = 1'b1;
    next_cycle();

    // Forwarding and youngest-match rule on rd 5
    sb_if.rs1_i = 5'd5; sb_if.rs2_i = 5'd0;
    alloc_set(5'd5);
    push(2'd1, 5'd5, 64'hDEAD, 1'b0, 64'h0);
    next_cycle();
    wb(0, 2'd1, 64'hDEAD, 1'b0, 64'h0);
    @(negedge clk);
    chk("alloc_clears_valid", 64'(sb_if.commit_valid_o), 64'd0);
    next_cycle();
    alloc_set(5'd5);
    push(2'd2, 5'd5, 64'hBEEF, 1'b0, 64'h0);
    @(negedge clk);
    chk("fwd_busy", 64'(sb_if.rs1_busy_o), 64'd1);
    chk("fwd_valid", 64'(sb_if.rs1_valid_o), 64'(FWD));
    chk("fwd_data", sb_if.rs1_o, FWD ? 64'hDEAD : 64'h0);
    chk("fwd_x0_busy", 64'(sb_if.rs2_busy_o), 64'd0);
    chk("young_id", 64'(sb_if.issue_trans_id_o), 64'd2);
    next_cycle();
    wb(0, 2'd2, 64'hBEEF, 1'b0, 64'h0);
    @(negedge clk);
    chk("young_busy", 64'(sb_if.rs1_busy_o), 64'd1);
    chk("young_valid", 64'(sb_if.rs1_valid_o), 64'd0);
    chk("young_data", sb_if.rs1_o, 64'h0);
    next_cycle();
    @(negedge clk);
    chk("young_fwd_valid", 64'(sb_if.rs1_valid_o), 64'(FWD));
    chk("young_fwd_data", sb_if.rs1_o, FWD ? 64'hBEEF : 64'h0);
    next_cycle();
    sb_if.commit_ack_i = 1'b1;
    @(posedge clk); #1;
    next_cycle();
    @(negedge clk);
    chk("rd5_retired_busy", 64'(sb_if.rs1_busy_o), 64'd0);
    next_cycle();

    // Reset asserted mid-operation discards in-flight state
    sb_if.rs1_i = 5'd7;
    alloc_set(5'd7);
    next_cycle();
    wb(0, 2'd3, 64'h77, 1'b0, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(sb_if.rs1_busy_o), 64'd0);
    chk("midrst_issue_id", 64'(sb_if.issue_trans_id_o), 64'd0);
    chk("midrst_cv", 64'(sb_if.commit_valid_o), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_busy", 64'(sb_if.rs1_busy_o), 64'd0);
    next_cycle();

    // Wrap: six instructions, sixth reuses id 1
    for (int n = 0; n < 6; n++) begin
      alloc_set(5'(10 + n));
      push(2'(n % 4), 5'(10 + n), 64'h1000 + 64'(n), 1'b0, 64'h0);
      @(negedge clk);
      chk("wrap_ack", 64'(sb_if.decoded_instr_ack_o), 64'd1);
      chk("wrap_id", 64'(sb_if.issue_trans_id_o), 64'(n % 4));
      next_cycle();
      wb(n % 4, 2'(n % 4), 64'h1000 + 64'(n), 1'b0, 64'h0);
      next_cycle();
      sb_if.commit_ack_i = 1'b1;
      @(negedge clk);
      chk("wrap_cv", 64'(sb_if.commit_valid_o), 64'd1);
      next_cycle();
    end

    // Flush together with allocate, writeback and commit
    sb_if.rs1_i = 5'd20;
    alloc_set(5'd20);
    push(2'd2, 5'd20, 64'h2020, 1'b0, 64'h0);
    next_cycle();
    alloc_set(5'd21);
    push(2'd3, 5'd21, 64'h3030, 1'b0, 64'h0);
    next_cycle();
    wb(0, 2'd2, 64'h2020, 1'b0, 64'h0);
    next_cycle();
    sb_if.flush_i      = 1'b1;
    sb_if.commit_ack_i = 1'b1;
    alloc_set(5'd22);
    wb(1, 2'd3, 64'h3030, 1'b0, 64'h0);
    @(negedge clk);
    chk("flush_cv", 64'(sb_if.commit_valid_o), 64'd0);
    chk("flush_ack", 64'(sb_if.decoded_instr_ack_o), 64'd0);
    chk("flush_busy_pre", 64'(sb_if.rs1_busy_o), 64'd1);
    next_cycle();
    exp_q.delete();
    @(negedge clk);
    chk("postflush_cv", 64'(sb_if.commit_valid_o), 64'd0);
    chk("postflush_full", 64'(sb_if.full_o), 64'd0);
    chk("postflush_issue_id", 64'(sb_if.issue_trans_id_o), 64'd0);
    chk("postflush_busy", 64'(sb_if.rs1_busy_o), 64'd0);
    chk("postflush_head_valid", 64'(sb_if.commit_instr_o.valid), 64'd0);
    next_cycle();

    // Normal operation resumes at id 0
    alloc_set(5'd23);
    push(2'd0, 5'd23, 64'h55, 1'b0, 64'h0);
    next_cycle();
    wb(2, 2'd0, 64'h55, 1'b0, 64'h0);
    next_cycle();
    sb_if.commit_ack_i = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("end_cv", 64'(sb_if.commit_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
